audio_sample_scheduler: RTL and testbench

- Sequences the I2S output path from one system clock.
- Generates audio_mclk, audio_sck and audio_lrck by clock division.
- Once per audio frame, arbitrates or mixes two 16-bit stereo sample sources into the left/right words that the downstream parallel-to-serial serializer latches on the lrck falling edge.
- Reports source underruns.
- Sits between the tone/effect generators and the serializer.

---
 rtl/audio_sample_scheduler.sv | 178 +++++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// I2S output-path sequencer: divides clk into mclk/sck/lrck and, once per frame,
// selects or mixes two stereo sources into the words the serializer latches.
module audio_sample_scheduler #(
  parameter int unsigned SCK_BIT          = 3,
  parameter int unsigned LRCK_BIT         = 8,
  parameter int unsigned MCLK_BIT         = 1,
  parameter int unsigned FETCH_POINT      = 384,
  parameter bit          HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        mute,
  input  logic        src0_valid,
  input  logic [15:0] src0_left,
  input  logic [15:0] src0_right,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [15:0] src1_left,
  input  logic [15:0] src1_right,
  output logic        src1_ready,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic [15:0] audio_in_left,
  output logic [15:0] audio_in_right,
  output logic        frame_tick,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned    DW        = LRCK_BIT + 1;
  localparam logic [DW-1:0]  FETCH_CNT = DW'(FETCH_POINT);
  localparam logic [DW-1:0]  TICK_PRE  = {{(DW-1){1'b1}}, 1'b0};
  localparam logic [DW-1:0]  DIV_ONE   = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Two's-complement add clamped to the 16-bit range.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] == sum[15]) begin
      sat_add16 = sum[15:0];
    end else if (sum[16]) begin
      sat_add16 = 16'h8000;
    end else begin
      sat_add16 = 16'h7FFF;
    end
  endfunction

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0]   next_l_q, next_l_d, next_r_q, next_r_d;
  logic [15:0]   out_l_q, out_l_d, out_r_q, out_r_d;
  logic [15:0]   uc_q, uc_d;
  logic          tick_q, tick_d;
  logic          take0_s, take1_s;

  // Next-state logic: divider, frame FSM, source selection and commit.
  always_comb begin
    div_d    = div_q + DIV_ONE;
    state_d  = state_q;
    next_l_d = next_l_q;
    next_r_d = next_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    uc_d     = uc_q;
    tick_d   = (div_q == TICK_PRE);
    take0_s  = 1'b0;
    take1_s  = 1'b0;

    case (state_q)
      IDLE: begin
        // Enter FETCH on the edge where the divider reaches FETCH_CNT.
        if (div_d == FETCH_CNT) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        case (mode)
          2'd0: take0_s = src0_valid;
          2'd1: take1_s = src1_valid;
          2'd2: begin
            take1_s = src1_valid;
            take0_s = src0_valid & ~src1_valid;
          end
          2'd3: begin
            take0_s = src0_valid;
            take1_s = src1_valid;
          end
          default: begin
            take0_s = 1'b0;
            take1_s = 1'b0;
          end
        endcase

        if (take0_s && take1_s) begin
          next_l_d = sat_add16(src0_left, src1_left);
          next_r_d = sat_add16(src0_right, src1_right);
        end else if (take0_s) begin
          next_l_d = src0_left;
          next_r_d = src0_right;
        end else if (take1_s) begin
          next_l_d = src1_left;
          next_r_d = src1_right;
        end else begin
          if (HOLD_ON_UNDERRUN) begin
            next_l_d = next_l_q;
            next_r_d = next_r_q;
          end else begin
            next_l_d = 16'h0000;
            next_r_d = 16'h0000;
          end
          if (uc_q != 16'hFFFF) begin
            uc_d = uc_q + 16'd1;
          end else begin
            uc_d = uc_q;
          end
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        // Mute only gates the committed words; next_l/next_r keep real audio.
        if (mute) begin
          out_l_d = 16'h0000;
          out_r_d = 16'h0000;
        end else begin
          out_l_d = next_l_q;
          out_r_d = next_r_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      next_l_q <= 16'h0000;
      next_r_q <= 16'h0000;
      out_l_q  <= 16'h0000;
      out_r_q  <= 16'h0000;
      uc_q     <= 16'h0000;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      next_l_q <= next_l_d;
      next_r_q <= next_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      uc_q     <= uc_d;
      tick_q   <= tick_d;
    end
  end

  assign audio_mclk     = div_q[MCLK_BIT];
  assign audio_sck      = div_q[SCK_BIT];
  assign audio_lrck     = div_q[LRCK_BIT];
  assign audio_in_left  = out_l_q;
  assign audio_in_right = out_r_q;
  assign frame_tick     = tick_q;
  assign underrun_cnt   = uc_q;
  assign src0_ready     = take0_s;
  assign src1_ready     = take1_s;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: two instances (hold / zero on underrun) driven
// in parallel and compared frame by frame against a behavioural frame model.
module tb_audio_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        mute = 1'b0;
  logic        s0v = 1'b0, s1v = 1'b0;
  logic [15:0] s0l = 16'h0, s0r = 16'h0, s1l = 16'h0, s1r = 16'h0;

  logic        h_rdy0, h_rdy1, h_mclk, h_sck, h_lrck, h_tick;
  logic [15:0] h_l, h_r, h_uc;
  logic        z_rdy0, z_rdy1, z_mclk, z_sck, z_lrck, z_tick;
  logic [15:0] z_l, z_r, z_uc;

  audio_sample_scheduler #(.HOLD_ON_UNDERRUN(1'b1)) dut_hold (
    .clk(clk), .rst(rst), .mode(mode), .mute(mute),
    .src0_valid(s0v), .src0_left(s0l), .src0_right(s0r), .src0_ready(h_rdy0),
    .src1_valid(s1v), .src1_left(s1l), .src1_right(s1r), .src1_ready(h_rdy1),
    .audio_mclk(h_mclk), .audio_sck(h_sck), .audio_lrck(h_lrck),
    .audio_in_left(h_l), .audio_in_right(h_r),
    .frame_tick(h_tick), .underrun_cnt(h_uc)
  );

  audio_sample_scheduler #(.HOLD_ON_UNDERRUN(1'b0)) dut_zero (
    .clk(clk), .rst(rst), .mode(mode), .mute(mute),
    .src0_valid(s0v), .src0_left(s0l), .src0_right(s0r), .src0_ready(z_rdy0),
    .src1_valid(s1v), .src1_left(s1l), .src1_right(s1r), .src1_ready(z_rdy1),
    .audio_mclk(z_mclk), .audio_sck(z_sck), .audio_lrck(z_lrck),
    .audio_in_left(z_l), .audio_in_right(z_r),
    .frame_tick(z_tick), .underrun_cnt(z_uc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [8:0] exp_div = 9'd0;

  // Model state
  logic [15:0] m_hl = 16'h0, m_hr = 16'h0, m_zl = 16'h0, m_zr = 16'h0;
  logic [15:0] m_ohl = 16'h0, m_ohr = 16'h0, m_ozl = 16'h0, m_ozr = 16'h0;
  logic [15:0] m_pre_hl = 16'h0, m_pre_hr = 16'h0, m_uc = 16'h0;
  logic        m_c0 = 1'b0, m_c1 = 1'b0;

  // Frame observations
  logic        o_rdy0, o_rdy1, o_tick_end;
  logic [15:0] o_pre_l, o_pre_r, o_post_l, o_post_r, o_end_l, o_end_r;
  logic [15:0] o_zpost_l, o_zpost_r, o_uc, o_zuc;
  int          o_n0, o_n1, o_zn0, o_zn1, o_ntick;

  function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    exp_div = exp_div + 9'd1;
  endtask

  task automatic set_in(input logic [1:0] m, input logic mu,
                        input logic v0, input logic [15:0] l0, input logic [15:0] r0,
                        input logic v1, input logic [15:0] l1, input logic [15:0] r1);
    mode = m; mute = mu;
    s0v = v0; s0l = l0; s0r = r0;
    s1v = v1; s1l = l1; s1r = r1;
  endtask

  // What one frame should do, given the inputs currently applied.
  task automatic model_frame();
    logic c0, c1;
    logic [15:0] dl, dr;
    dl = 16'h0; dr = 16'h0;
    m_pre_hl = m_ohl; m_pre_hr = m_ohr;
    c1 = s1v && (mode == 2'd1 || mode == 2'd2 || mode == 2'd3);
    c0 = s0v && (mode == 2'd0 || mode == 2'd3 || (mode == 2'd2 && !s1v));
    if (c0 && c1) begin dl = mix(s0l, s1l); dr = mix(s0r, s1r); end
    else if (c0) begin dl = s0l; dr = s0r; end
    else if (c1) begin dl = s1l; dr = s1r; end
    if (c0 || c1) begin
      m_hl = dl; m_hr = dr; m_zl = dl; m_zr = dr;
    end else begin
      m_zl = 16'h0; m_zr = 16'h0;
      if (m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
    end
    m_ohl = mute ? 16'h0 : m_hl;  m_ohr = mute ? 16'h0 : m_hr;
    m_ozl = mute ? 16'h0 : m_zl;  m_ozr = mute ? 16'h0 : m_zr;
    m_c0 = c0; m_c1 = c1;
  endtask

  task automatic model_reset();
    m_hl = 16'h0; m_hr = 16'h0; m_zl = 16'h0; m_zr = 16'h0;
    m_ohl = 16'h0; m_ohr = 16'h0; m_ozl = 16'h0; m_ozr = 16'h0;
    m_uc = 16'h0;
  endtask

  // Runs one full frame from div 0 back to div 0, recording observations.
  task automatic step_frame();
    o_n0 = 0; o_n1 = 0; o_zn0 = 0; o_zn1 = 0; o_ntick = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (h_rdy0) o_n0++;
      if (h_rdy1) o_n1++;
      if (z_rdy0) o_zn0++;
      if (z_rdy1) o_zn1++;
      if (h_tick) o_ntick++;
      if (exp_div == 9'd384) begin o_rdy0 = h_rdy0; o_rdy1 = h_rdy1; end
      if (exp_div == 9'd385) begin o_pre_l = h_l; o_pre_r = h_r; end
      if (exp_div == 9'd386) begin
        o_post_l = h_l; o_post_r = h_r; o_zpost_l = z_l; o_zpost_r = z_r;
        o_uc = h_uc; o_zuc = z_uc;
      end
      if (exp_div == 9'd511) begin o_end_l = h_l; o_end_r = h_r; o_tick_end = h_tick; end
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({h_l, h_r, h_uc, h_rdy0, h_rdy1, h_mclk, h_sck, h_lrck, h_tick} !== 54'd0)
      $display("FAIL reset_outputs got %h/%h uc=%h ctl=%b%b%b%b%b%b want all 0",
               h_l, h_r, h_uc, h_rdy0, h_rdy1, h_mclk, h_sck, h_lrck, h_tick);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_div = 9'd0;
    model_reset();
    set_in(2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    model_frame();
    for (int i = 0; i < 512; i++) begin
      tick();
      n_total++;
      if ({h_mclk, h_sck, h_lrck, h_tick, h_rdy0, h_rdy1} !==
          {exp_div[1], exp_div[3], exp_div[8], (exp_div == 9'd511), 1'b0, 1'b0})
        $display("FAIL clocks div=%0d got mclk/sck/lrck/tick/r0/r1=%b%b%b%b%b%b want %b%b%b%b00",
                 exp_div, h_mclk, h_sck, h_lrck, h_tick, h_rdy0, h_rdy1,
                 exp_div[1], exp_div[3], exp_div[8], (exp_div == 9'd511));
      else n_pass++;
      n_total++;
      if ({h_l, h_r} !== 32'd0) $display("FAIL idle_words div=%0d got %h/%h want 0/0", exp_div, h_l, h_r);
      else n_pass++;
      if (exp_div == 9'd386) begin
        n_total++;
        if (h_uc !== 16'd1) $display("FAIL uc_frame0 got %0d want 1", h_uc);
        else n_pass++;
      end
    end
    model_frame();
    step_frame();
    n_total++;
    if (o_uc !== 16'd2 || o_uc !== m_uc) $display("FAIL uc_frame1 got %0d want 2", o_uc);
    else n_pass++;
    n_total++;
    if (o_ntick != 1 || o_tick_end !== 1'b1) $display("FAIL frame_tick got %0d pulses end=%b want 1 at 511", o_ntick, o_tick_end);
    else n_pass++;
  endtask

  task automatic test_mode0();
    set_in(2'd0, 1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b1, 16'h5555, 16'h6666);
    model_frame();
    step_frame();
    n_total++;
    if (o_rdy0 !== 1'b1 || o_n0 != 1 || o_n1 != 0)
      $display("FAIL mode0_ready got r0@384=%b n0=%0d n1=%0d want 1/1/0", o_rdy0, o_n0, o_n1);
    else n_pass++;
    n_total++;
    if ({o_post_l, o_post_r, o_end_l, o_end_r} !== {16'h1234, 16'hABCD, 16'h1234, 16'hABCD})
      $display("FAIL mode0_words got %h/%h end %h/%h want 1234/abcd", o_post_l, o_post_r, o_end_l, o_end_r);
    else n_pass++;
    n_total++;
    if ({o_pre_l, o_pre_r} !== {m_pre_hl, m_pre_hr})
      $display("FAIL mode0_early got %h/%h at 385 want %h/%h", o_pre_l, o_pre_r, m_pre_hl, m_pre_hr);
    else n_pass++;
  endtask

  task automatic test_mode2();
    set_in(2'd2, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b1, 16'h0100, 16'h0200);
    model_frame();
    step_frame();
    n_total++;
    if (o_n0 != 0 || o_n1 != 1 || o_rdy1 !== 1'b1)
      $display("FAIL mode2_prio_ready got n0=%0d n1=%0d want 0/1", o_n0, o_n1);
    else n_pass++;
    n_total++;
    if ({o_post_l, o_post_r} !== {16'h0100, 16'h0200})
      $display("FAIL mode2_prio_words got %h/%h want 0100/0200", o_post_l, o_post_r);
    else n_pass++;
    set_in(2'd2, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0100, 16'h0200);
    model_frame();
    step_frame();
    n_total++;
    if (o_n0 != 1 || o_n1 != 0 || {o_post_l, o_post_r} !== {16'h0001, 16'h0002})
      $display("FAIL mode2_fallback got n0=%0d n1=%0d %h/%h want 1/0 0001/0002", o_n0, o_n1, o_post_l, o_post_r);
    else n_pass++;
  endtask

  task automatic test_mode3_sat();
    set_in(2'd3, 1'b0, 1'b1, 16'h7000, 16'h8000, 1'b1, 16'h2000, 16'hF000);
    model_frame();
    step_frame();
    n_total++;
    if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b1 || o_n0 != 1 || o_n1 != 1)
      $display("FAIL mode3_ready got r0=%b r1=%b n0=%0d n1=%0d want both once together", o_rdy0, o_rdy1, o_n0, o_n1);
    else n_pass++;
    n_total++;
    if ({o_post_l, o_post_r} !== {16'h7FFF, 16'h8000})
      $display("FAIL mode3_sat got %h/%h want 7fff/8000", o_post_l, o_post_r);
    else n_pass++;
  endtask

  task automatic test_underrun_hold();
    logic [15:0] uc0;
    set_in(2'd0, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 16'h0, 16'h0);
    model_frame();
    step_frame();
    uc0 = o_uc;
    n_total++;
    if ({o_post_l, o_post_r, o_zpost_l, o_zpost_r} !== {16'h1111, 16'h2222, 16'h1111, 16'h2222})
      $display("FAIL underrun_setup got %h/%h zero-inst %h/%h want 1111/2222", o_post_l, o_post_r, o_zpost_l, o_zpost_r);
    else n_pass++;
    set_in(2'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1, 16'h3333, 16'h4444);
    model_frame();
    step_frame();
    n_total++;
    if ({o_post_l, o_post_r} !== {16'h1111, 16'h2222} || o_n0 != 0 || o_n1 != 0)
      $display("FAIL underrun_hold got %h/%h n0=%0d n1=%0d want 1111/2222 no ready", o_post_l, o_post_r, o_n0, o_n1);
    else n_pass++;
    n_total++;
    if ({o_zpost_l, o_zpost_r} !== 32'd0)
      $display("FAIL underrun_zero got %h/%h want 0000/0000", o_zpost_l, o_zpost_r);
    else n_pass++;
    n_total++;
    if (o_uc !== uc0 + 16'd1 || o_zuc !== m_uc)
      $display("FAIL underrun_cnt got %0d/%0d want %0d", o_uc, o_zuc, uc0 + 16'd1);
    else n_pass++;
  endtask

  task automatic test_mute();
    set_in(2'd0, 1'b1, 1'b1, 16'h5A5A, 16'hA5A5, 1'b0, 16'h0, 16'h0);
    model_frame();
    step_frame();
    n_total++;
    if (o_rdy0 !== 1'b1 || {o_post_l, o_post_r} !== 32'd0)
      $display("FAIL mute_consume got r0=%b %h/%h want 1 0000/0000", o_rdy0, o_post_l, o_post_r);
    else n_pass++;
    set_in(2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    model_frame();
    step_frame();
    n_total++;
    if ({o_post_l, o_post_r} !== {16'h5A5A, 16'hA5A5})
      $display("FAIL unmute_hold got %h/%h want 5a5a/a5a5", o_post_l, o_post_r);
    else n_pass++;
  endtask

  task automatic test_midframe_reset();
    set_in(2'd0, 1'b0, 1'b1, 16'h0BAD, 16'h0F00, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 200; i++) tick();
    rst = 1'b1;
    #1;
    n_total++;
    if ({h_l, h_r, h_uc, h_rdy0, h_rdy1, h_mclk, h_sck, h_lrck, h_tick} !== 54'd0)
      $display("FAIL midreset_clear got %h/%h uc=%h ctl=%b%b%b%b%b%b want all 0",
               h_l, h_r, h_uc, h_rdy0, h_rdy1, h_mclk, h_sck, h_lrck, h_tick);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_div = 9'd0;
    model_reset();
    model_frame();
    step_frame();
    n_total++;
    if ({o_pre_l, o_pre_r} !== 32'd0 || {o_post_l, o_post_r} !== {16'h0BAD, 16'h0F00})
      $display("FAIL midreset_restart got %h/%h at 385, %h/%h at 386 want 0/0 then 0bad/0f00",
               o_pre_l, o_pre_r, o_post_l, o_post_r);
    else n_pass++;
    n_total++;
    if (o_uc !== 16'd0 || o_tick_end !== 1'b1)
      $display("FAIL midreset_counters got uc=%0d tick@511=%b want 0/1", o_uc, o_tick_end);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      set_in(2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      model_frame();
      step_frame();
      n_total++;
      if (o_n0 != (m_c0 ? 1 : 0) || o_n1 != (m_c1 ? 1 : 0) || {o_rdy0, o_rdy1} !== {m_c0, m_c1} ||
          o_zn0 != o_n0 || o_zn1 != o_n1)
        $display("FAIL rand_ready frame %0d got n0=%0d n1=%0d r@384=%b%b want %b%b", f, o_n0, o_n1, o_rdy0, o_rdy1, m_c0, m_c1);
      else n_pass++;
      n_total++;
      if ({o_pre_l, o_pre_r, o_post_l, o_post_r, o_end_l, o_end_r} !== {m_pre_hl, m_pre_hr, m_ohl, m_ohr, m_ohl, m_ohr})
        $display("FAIL rand_words frame %0d got %h/%h->%h/%h end %h/%h want %h/%h->%h/%h", f,
                 o_pre_l, o_pre_r, o_post_l, o_post_r, o_end_l, o_end_r, m_pre_hl, m_pre_hr, m_ohl, m_ohr);
      else n_pass++;
      n_total++;
      if ({o_zpost_l, o_zpost_r} !== {m_ozl, m_ozr})
        $display("FAIL rand_zero_words frame %0d got %h/%h want %h/%h", f, o_zpost_l, o_zpost_r, m_ozl, m_ozr);
      else n_pass++;
      n_total++;
      if (o_uc !== m_uc || o_zuc !== m_uc || o_ntick != 1)
        $display("FAIL rand_uc frame %0d got %0d/%0d ticks=%0d want %0d/1", f, o_uc, o_zuc, o_ntick, m_uc);
      else n_pass++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_mode0();
    test_mode2();
    test_mode3_sat();
    test_underrun_hold();
    test_mute();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
